// File: rtl/three_bit_counter.sv
// ---------------------------------------------------------------------------
// three_bit_counter
//
// Purpose:
//   Counts qualified "level complete" events and presents the running count
//   as a difficulty level for the car-traffic speed selection.
//
//   The input is the combinational win strobe. It is treated as a level.
//   Only its 0->1 transitions are counted, so a win level that is held high
//   never over-counts. The count is registered. Depending on SATURATE, it
//   either saturates at MAX_COUNT or wraps back to 0.
//
// Parameters:
//   WIDTH      counter/output width in bits
//   MAX_COUNT  terminal count value; must not exceed 2**WIDTH-1
//   SATURATE   1: hold at MAX_COUNT, 0: wrap from MAX_COUNT to 0
//
// Ports:
//   clk    in   1      system clock, all state updates on the rising edge
//   reset  in   1      synchronous, active-high reset
//   in     in   1      win strobe level, sampled on clk
//   out    out  WIDTH  current count (difficulty level), straight from a flop
// ---------------------------------------------------------------------------
module three_bit_counter #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7,
  parameter bit SATURATE  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_inQ;
  logic             w_rise;

  // One increment per 0->1 transition of the strobe, however long it stays high.
  assign w_rise = in & ~r_inQ;

  // The previous-sample flop also loads during reset. As a result, a strobe
  // that is already high when reset is released does not look like a fresh
  // rising edge. Reset wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    r_inQ <= in;
    if (reset) begin
      r_count <= '0;
    end else if (w_rise) begin
      if (r_count < MaxCount) begin
        r_count <= r_count + One;
      end else if (SATURATE) begin
        r_count <= r_count;
      end else begin
        r_count <= '0;
      end
    end
  end

  assign out = r_count;

endmodule

// File: tb/tb_three_bit_counter.sv
// ---------------------------------------------------------------------------
// tb_three_bit_counter
//
// Drives one saturating instance and one wrapping instance of
// three_bit_counter from the same stimulus.
//
// For every driven cycle, a reference model records how many rising edges
// of the strobe have occurred since the last reset. It maps that count to
// the expected level:
//   - saturating instance: min(rises, 7)
//   - wrapping instance:   rises mod 8
// The model pushes both expected levels into a queue. An independent
// monitor pops one entry after every rising clock edge and compares it
// against both outputs.
// ---------------------------------------------------------------------------
module tb_three_bit_counter;

  typedef struct {
    int    expSat;
    int    expWrap;
    string tag;
  } expect_t;

  logic       clk;
  logic       reset;
  logic       in;
  logic [2:0] outSat;
  logic [2:0] outWrap;

  expect_t scoreQ[$];
  int      checks;
  int      failures;

  // Reference model state.
  logic modelPrev;
  int   modelRises;

  three_bit_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b1)) dutSat (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (outSat)
  );

  three_bit_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b0)) dutWrap (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (outWrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of stimulus on the falling edge.
  // Records what both counters must show after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic inVal, input string tag);
    expect_t e;
    @(negedge clk);
    reset = rst;
    in    = inVal;
    if (rst) begin
      modelRises = 0;
      modelPrev  = (inVal === 1'b1);
    end else begin
      if (inVal === 1'b1 && modelPrev !== 1'b1) modelRises++;
      modelPrev = (inVal === 1'b1);
    end
    e.expSat  = (modelRises > 7) ? 7 : modelRises;
    e.expWrap = modelRises % 8;
    e.tag     = tag;
    scoreQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] actual, input int expected);
    checks++;
    if (actual !== 3'(expected)) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Monitor: one expected entry per rising edge.
  // Outputs are sampled just after the edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput({e.tag, "/sat"},  outSat,  e.expSat);
        checkOutput({e.tag, "/wrap"}, outWrap, e.expWrap);
      end
    end
  end

  initial begin
    int drain;
    checks     = 0;
    failures   = 0;
    modelPrev  = 1'b0;
    modelRises = 0;
    reset      = 1'b1;
    in         = 1'b0;

    // Reset with the strobe low, then a quiet period.
    applyStimulus(1'b1, 1'b0, "reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, "idle");

    // Three single-cycle pulses, each followed by a low cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, "pulse");
      applyStimulus(1'b0, 1'b0, "pulseLow");
    end

    // Strobe held high for four cycles counts once; a later pulse counts again.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, "held");
    applyStimulus(1'b0, 1'b0, "heldLow");
    applyStimulus(1'b0, 1'b1, "afterHeld");
    applyStimulus(1'b0, 1'b0, "afterHeldLow");

    // Eight separated pulses from zero: saturates at 7, wraps to 0.
    applyStimulus(1'b1, 1'b0, "reset8");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, "eight");
      applyStimulus(1'b0, 1'b0, "eightLow");
    end
    applyStimulus(1'b0, 1'b1, "ninth");
    applyStimulus(1'b0, 1'b0, "ninthLow");

    // Reach 5, then reset while the strobe is high and keep it high.
    applyStimulus(1'b1, 1'b0, "reset5");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, "toFive");
      applyStimulus(1'b0, 1'b0, "toFiveLow");
    end
    applyStimulus(1'b0, 1'b1, "highBeforeReset");
    applyStimulus(1'b1, 1'b1, "resetHigh");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "heldAfterReset");
    applyStimulus(1'b0, 1'b0, "fallAfterReset");
    applyStimulus(1'b0, 1'b1, "riseAfterReset");

    // Back-to-back alternating pulses.
    applyStimulus(1'b1, 1'b0, "resetAlt");
    applyStimulus(1'b0, 1'b1, "alt");
    applyStimulus(1'b0, 1'b0, "alt");
    applyStimulus(1'b0, 1'b1, "alt");
    applyStimulus(1'b0, 1'b0, "alt");
    applyStimulus(1'b0, 1'b1, "alt");
    applyStimulus(1'b0, 1'b0, "altEnd");

    // Unknown strobe during reset must not disturb the count.
    applyStimulus(1'b1, 1'bx, "resetX");
    applyStimulus(1'b0, 1'b0, "afterX");
    applyStimulus(1'b0, 1'b1, "afterXPulse");
    applyStimulus(1'b0, 1'b0, "afterXLow");

    // Random strobe with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), "random");
    end
    applyStimulus(1'b0, 1'b0, "tail");

    // Let the monitor drain the queue, with a bounded wait.
    drain = 0;
    while (scoreQ.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (scoreQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: actual=%0d pending entries required=0", scoreQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
